// File: rtl/store_stage_receiver_pkg.sv
// Shared types for the execute->store bus and the storage stage.
package store_stage_receiver_pkg;

  localparam int unsigned NUMBER_OF_LANES = 8;
  localparam int unsigned LANE_IDX_W      = $clog2(NUMBER_OF_LANES);

  typedef logic [31:0]                    lane_value_t;
  typedef logic [31:0]                    memory_address_t;
  typedef logic [NUMBER_OF_LANES-1:0]     execution_mask_t;
  typedef logic [4:0]                     RegisterID;
  typedef logic [LANE_IDX_W-1:0]          lane_idx_t;
  typedef lane_value_t [NUMBER_OF_LANES-1:0] VectorValue;

  typedef enum logic [2:0] {
    STORAGE_NOP       = 3'd0,
    STORAGE_STORE_REG = 3'd1,
    STORAGE_STORE_MEM = 3'd2,
    STORAGE_JMP       = 3'd3,
    STORAGE_CJMP      = 3'd4
  } StorageStageOpcode;

  typedef struct packed {
    RegisterID       regID;
    VectorValue      value;
    memory_address_t address;
  } ExecStageValue;

  typedef struct packed {
    StorageStageOpcode opcode;
    ExecStageValue     dest;
    ExecStageValue     src;
    execution_mask_t   exec_mask;
    execution_mask_t   execution_flags_true;
    execution_mask_t   execution_flags_false;
    logic              is_store_to_pc;
  } ExecStagePacket;

  typedef struct packed {
    memory_address_t pc;
    execution_mask_t mask;
  } diverge_entry_t;

endpackage

// File: rtl/store_stage_receiver_diverge_stack.sv
// LIFO of pending {PC, exec_mask} for the untaken side of divergent branches.
module store_stage_receiver_diverge_stack
  import store_stage_receiver_pkg::*;
#(
  parameter int unsigned DIVERGE_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_push,
  input  logic           i_pop,
  input  diverge_entry_t i_entry,
  output diverge_entry_t o_top,
  output logic           o_full,
  output logic           o_empty,
  output logic           o_overflow
);

  localparam int unsigned CntW = $clog2(DIVERGE_DEPTH + 1);
  localparam int unsigned IdxW = (DIVERGE_DEPTH > 1) ? $clog2(DIVERGE_DEPTH) : 1;

  diverge_entry_t r_entries [DIVERGE_DEPTH];
  logic [CntW-1:0] r_count;
  logic            r_overflow;
  logic [IdxW-1:0] w_wr_idx;
  logic [IdxW-1:0] w_top_idx;

  assign o_full     = (r_count == CntW'(DIVERGE_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_overflow = r_overflow;
  assign w_wr_idx   = IdxW'(r_count);
  assign w_top_idx  = IdxW'(r_count - CntW'(1));
  assign o_top      = r_entries[w_top_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < int'(DIVERGE_DEPTH); i++) r_entries[i] <= '0;
    end else if (i_push) begin
      // A push on a full stack loses the entry; the sticky flag records it.
      if (o_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_entries[w_wr_idx] <= i_entry;
        r_count             <= r_count + CntW'(1);
      end
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - CntW'(1);
    end
  end

endmodule

// File: rtl/store_stage_receiver.sv
// Storage stage: takes one packet off the execute->store bus and performs its writeback,
// scatter store, PC update or divergent branch.
module store_stage_receiver
  import store_stage_receiver_pkg::*;
#(
  parameter int unsigned DIVERGE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            bus_is_busy,
  input  ExecStagePacket  bus_data,
  output logic            bus_recv,
  output logic            rf_we,
  output RegisterID       rf_id,
  output VectorValue      rf_value,
  output execution_mask_t rf_mask,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output memory_address_t mem_addr,
  output lane_value_t     mem_data,
  output logic            pc_we,
  output memory_address_t pc_value,
  output execution_mask_t exec_mask_out,
  output logic            stack_overflow,
  output logic            idle
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM} state_t;

  state_t          r_state;
  ExecStagePacket  r_pkt;
  lane_idx_t       r_lane_idx;
  logic            r_bus_recv, r_rf_we, r_mem_req_valid, r_pc_we, r_idle;
  RegisterID       r_rf_id;
  VectorValue      r_rf_value;
  execution_mask_t r_rf_mask, r_exec_mask_out;
  memory_address_t r_mem_addr, r_pc_value;
  lane_value_t     r_mem_data;

  execution_mask_t w_t, w_f, w_above;
  lane_idx_t       w_first_lane, w_next_lane;
  logic            w_is_cjmp, w_push, w_pop, w_stack_empty, w_stack_full;
  diverge_entry_t  w_top, w_push_entry;
  logic            w_unused_regid;

  function automatic lane_idx_t lowest_lane(input execution_mask_t m);
    lowest_lane = '0;
    for (int i = NUMBER_OF_LANES - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = lane_idx_t'(i);
    end
  endfunction

  assign w_t          = r_pkt.execution_flags_true;
  assign w_f          = r_pkt.execution_flags_false;
  // Set lanes strictly above the lane currently being issued.
  assign w_above      = r_pkt.exec_mask &
                        ~((execution_mask_t'(2) << r_lane_idx) - execution_mask_t'(1));
  assign w_first_lane = lowest_lane(r_pkt.exec_mask);
  assign w_next_lane  = lowest_lane(w_above);
  assign w_is_cjmp    = (r_state == S_EXEC) && (r_pkt.opcode == STORAGE_CJMP);
  assign w_push       = w_is_cjmp && (|w_t) && (|w_f);
  assign w_pop        = w_is_cjmp && !(|w_t) && !(|w_f) && !w_stack_empty;
  assign w_push_entry = '{pc: r_pkt.src.address, mask: w_f};
  assign w_unused_regid = ^{r_pkt.src.regID, w_stack_full};

  store_stage_receiver_diverge_stack #(
    .DIVERGE_DEPTH(DIVERGE_DEPTH)
  ) u_diverge_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_entry   (w_push_entry),
    .o_top     (w_top),
    .o_full    (w_stack_full),
    .o_empty   (w_stack_empty),
    .o_overflow(stack_overflow)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_pkt           <= '0;
      r_lane_idx      <= '0;
      r_bus_recv      <= 1'b0;
      r_rf_we         <= 1'b0;
      r_rf_id         <= '0;
      r_rf_value      <= '0;
      r_rf_mask       <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_data      <= '0;
      r_pc_we         <= 1'b0;
      r_pc_value      <= '0;
      r_exec_mask_out <= '0;
      r_idle          <= 1'b0;
    end else begin
      r_bus_recv <= 1'b0;
      r_rf_we    <= 1'b0;
      r_pc_we    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus_is_busy) begin
            r_bus_recv <= 1'b1;
            r_pkt      <= bus_data;
            r_state    <= S_EXEC;
            r_idle     <= 1'b0;
          end else begin
            r_idle <= 1'b1;
          end
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
          case (r_pkt.opcode)
            STORAGE_STORE_REG: begin
              r_rf_we    <= 1'b1;
              r_rf_id    <= r_pkt.dest.regID;
              r_rf_value <= r_pkt.src.value;
              r_rf_mask  <= r_pkt.exec_mask;
              if (r_pkt.is_store_to_pc) begin
                r_pc_we         <= 1'b1;
                r_pc_value      <= r_pkt.src.value[0];
                r_exec_mask_out <= r_pkt.exec_mask;
              end
            end
            STORAGE_STORE_MEM: begin
              if (|r_pkt.exec_mask) begin
                r_lane_idx      <= w_first_lane;
                r_mem_req_valid <= 1'b1;
                r_mem_addr      <= r_pkt.dest.value[w_first_lane];
                r_mem_data      <= r_pkt.src.value[w_first_lane];
                r_state         <= S_MEM;
                r_idle          <= 1'b0;
              end
            end
            STORAGE_JMP: begin
              r_pc_we         <= 1'b1;
              r_pc_value      <= r_pkt.dest.address;
              r_exec_mask_out <= r_pkt.exec_mask;
            end
            STORAGE_CJMP: begin
              if (|w_t) begin
                r_pc_we         <= 1'b1;
                r_pc_value      <= r_pkt.dest.address;
                r_exec_mask_out <= w_t;
              end else if (|w_f) begin
                r_pc_we         <= 1'b1;
                r_pc_value      <= r_pkt.src.address;
                r_exec_mask_out <= w_f;
              end else if (!w_stack_empty) begin
                r_pc_we         <= 1'b1;
                r_pc_value      <= w_top.pc;
                r_exec_mask_out <= w_top.mask;
              end
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_req_ready) begin
            if (|w_above) begin
              r_lane_idx <= w_next_lane;
              r_mem_addr <= r_pkt.dest.value[w_next_lane];
              r_mem_data <= r_pkt.src.value[w_next_lane];
            end else begin
              r_mem_req_valid <= 1'b0;
              r_state         <= S_IDLE;
              r_idle          <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_recv      = r_bus_recv;
  assign rf_we         = r_rf_we;
  assign rf_id         = r_rf_id;
  assign rf_value      = r_rf_value;
  assign rf_mask       = r_rf_mask;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign mem_data      = r_mem_data;
  assign pc_we         = r_pc_we;
  assign pc_value      = r_pc_value;
  assign exec_mask_out = r_exec_mask_out;
  assign idle          = r_idle;

endmodule

// File: tb/tb_store_stage_receiver.sv
// Directed bench for store_stage_receiver with hand-computed expectations.
module tb_store_stage_receiver;
  import store_stage_receiver_pkg::*;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            bus_is_busy;
  ExecStagePacket  bus_data;
  logic            bus_recv, rf_we, mem_req_valid, mem_req_ready, pc_we, stack_overflow, idle;
  RegisterID       rf_id;
  VectorValue      rf_value;
  execution_mask_t rf_mask, exec_mask_out;
  memory_address_t mem_addr, pc_value;
  lane_value_t     mem_data;

  int checks = 0;
  int errors = 0;
  int recv_cnt = 0;
  logic prev_recv = 1'b0;
  logic double_recv = 1'b0;
  memory_address_t hs_q[$];

  store_stage_receiver #(.DIVERGE_DEPTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus_is_busy   (bus_is_busy),
    .bus_data      (bus_data),
    .bus_recv      (bus_recv),
    .rf_we         (rf_we),
    .rf_id         (rf_id),
    .rf_value      (rf_value),
    .rf_mask       (rf_mask),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .pc_we         (pc_we),
    .pc_value      (pc_value),
    .exec_mask_out (exec_mask_out),
    .stack_overflow(stack_overflow),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_recv) recv_cnt++;
    if (bus_recv && prev_recv) double_recv = 1'b1;
    prev_recv = bus_recv;
  end

  always @(posedge clk) begin
    if (reset_n && mem_req_valid && mem_req_ready) hs_q.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where bus_recv is high.
  task automatic send(input ExecStagePacket p);
    int n;
    n = 0;
    bus_data    = p;
    bus_is_busy = 1'b1;
    @(negedge clk);
    while (!bus_recv && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("bus_recv", bus_recv, 1'b1);
    bus_is_busy = 1'b0;
  endtask

  function automatic ExecStagePacket cjmp(input memory_address_t d, input memory_address_t s,
                                          input execution_mask_t t, input execution_mask_t f);
    ExecStagePacket p;
    p = '0;
    p.opcode                = STORAGE_CJMP;
    p.dest.address          = d;
    p.src.address           = s;
    p.execution_flags_true  = t;
    p.execution_flags_false = f;
    return p;
  endfunction

  initial begin
    ExecStagePacket p;
    int rc0, hs0;
    memory_address_t exp_lane_addr [3];
    lane_value_t     exp_lane_data [3];

    reset_n = 1'b0; bus_is_busy = 1'b0; mem_req_ready = 1'b0; bus_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_recv", bus_recv, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_pc_we", pc_we, 1'b0);
    chk("rst_ovf", stack_overflow, 1'b0);
    chk("rst_idle", idle, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", idle, 1'b1);

    // STORE_REG writeback
    p = '0;
    p.opcode = STORAGE_STORE_REG;
    p.dest.regID = 5'd3;
    for (int i = 0; i < 8; i++) p.src.value[i] = 32'(i + 1);
    p.exec_mask = 8'h0F;
    rc0 = recv_cnt;
    send(p);
    @(negedge clk);
    chk("sr_rf_we", rf_we, 1'b1);
    chk("sr_rf_id", rf_id, 5'd3);
    chk("sr_rf_mask", rf_mask, 8'h0F);
    chk("sr_rf_val", rf_value,
        256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    chk("sr_pc_we", pc_we, 1'b0);
    @(negedge clk);
    chk("sr_rf_we_pulse", rf_we, 1'b0);
    chk("sr_recv_once", recv_cnt - rc0, 1);

    // STORE_REG also targeting PC
    p = '0;
    p.opcode = STORAGE_STORE_REG;
    p.dest.regID = 5'd7;
    p.src.value[0] = 32'h40;
    p.exec_mask = 8'hFF;
    p.is_store_to_pc = 1'b1;
    send(p);
    @(negedge clk);
    chk("pc_rf_we", rf_we, 1'b1);
    chk("pc_pc_we", pc_we, 1'b1);
    chk("pc_value", pc_value, 32'h40);
    chk("pc_mask", exec_mask_out, 8'hFF);

    // Scatter store, lanes 0,5,7 with three stalled cycles each
    p = '0;
    p.opcode = STORAGE_STORE_MEM;
    for (int i = 0; i < 8; i++) begin
      p.dest.value[i] = 32'h1000 + 32'(4 * i);
      p.src.value[i]  = 32'hD0 + 32'(i);
    end
    p.exec_mask = 8'b1010_0001;
    exp_lane_addr = '{32'h1000, 32'h1014, 32'h101C};
    exp_lane_data = '{32'hD0, 32'hD5, 32'hD7};
    hs0 = hs_q.size();
    send(p);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 3; w++) begin
        chk("sm_valid_wait", mem_req_valid, 1'b1);
        chk("sm_addr_wait", mem_addr, exp_lane_addr[k]);
        chk("sm_data_wait", mem_data, exp_lane_data[k]);
        @(negedge clk);
      end
      mem_req_ready = 1'b1;
      chk("sm_addr_hs", mem_addr, exp_lane_addr[k]);
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
    chk("sm_valid_done", mem_req_valid, 1'b0);
    chk("sm_idle_done", idle, 1'b1);
    chk("sm_req_count", hs_q.size() - hs0, 3);
    if (hs_q.size() - hs0 == 3) begin
      for (int k = 0; k < 3; k++) chk("sm_order", hs_q[hs0 + k], exp_lane_addr[k]);
    end

    // Scatter store with empty mask
    p.exec_mask = 8'h00;
    hs0 = hs_q.size();
    send(p);
    @(negedge clk);
    chk("sm0_valid", mem_req_valid, 1'b0);
    chk("sm0_idle", idle, 1'b1);
    chk("sm0_count", hs_q.size() - hs0, 0);

    // Divergent CJMP then reconverging pop
    send(cjmp(32'h100, 32'h200, 8'h0F, 8'hF0));
    @(negedge clk);
    chk("cj_pc_we", pc_we, 1'b1);
    chk("cj_pc", pc_value, 32'h100);
    chk("cj_mask", exec_mask_out, 8'h0F);
    send(cjmp(32'h0, 32'h0, 8'h00, 8'h00));
    @(negedge clk);
    chk("cjpop_pc_we", pc_we, 1'b1);
    chk("cjpop_pc", pc_value, 32'h200);
    chk("cjpop_mask", exec_mask_out, 8'hF0);

    // Fill the stack past its depth, then drain it
    for (int i = 0; i < 5; i++) begin
      send(cjmp(32'h300 + 32'(i), 32'h400 + 32'(16 * i), 8'h01, 8'h10 + 8'(i)));
      @(negedge clk);
      chk("dv_pc_we", pc_we, 1'b1);
      chk("dv_pc", pc_value, 32'h300 + 32'(i));
      chk("dv_ovf", stack_overflow, (i == 4) ? 1'b1 : 1'b0);
    end
    for (int i = 3; i >= 0; i--) begin
      send(cjmp(32'h0, 32'h0, 8'h00, 8'h00));
      @(negedge clk);
      chk("dvpop_pc_we", pc_we, 1'b1);
      chk("dvpop_pc", pc_value, 32'h400 + 32'(16 * i));
      chk("dvpop_mask", exec_mask_out, 8'h10 + 8'(i));
    end
    send(cjmp(32'h0, 32'h0, 8'h00, 8'h00));
    @(negedge clk);
    chk("dvpop_empty_pc_we", pc_we, 1'b0);
    chk("dv_ovf_sticky", stack_overflow, 1'b1);

    // Unknown opcode behaves as NOP
    p = '0;
    p.opcode = StorageStageOpcode'(3'd7);
    p.exec_mask = 8'hFF;
    p.is_store_to_pc = 1'b1;
    send(p);
    @(negedge clk);
    chk("unk_rf_we", rf_we, 1'b0);
    chk("unk_pc_we", pc_we, 1'b0);
    chk("unk_mem_valid", mem_req_valid, 1'b0);

    // Reset while lane 2 of a scatter is pending
    p = '0;
    p.opcode = STORAGE_STORE_MEM;
    for (int i = 0; i < 8; i++) p.dest.value[i] = 32'h2000 + 32'(4 * i);
    p.exec_mask = 8'b0000_1101;
    send(p);
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rs_lane2_addr", mem_addr, 32'h2008);
    hs0 = hs_q.size();
    #2 reset_n = 1'b0;
    #1 chk("rs_valid_drop", mem_req_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_req_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rs_idle", idle, 1'b1);
    chk("rs_no_more_reqs", hs_q.size() - hs0, 0);
    chk("rs_ovf_cleared", stack_overflow, 1'b0);
    mem_req_ready = 1'b0;

    chk("recv_never_back_to_back", double_recv, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
